seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised multiplexed seven-segment display driver and the next-generation replacement for the fixed four-digit controller. It owns its own refresh prescaler, so no divided clock is needed. It scans 1–8 digits and adds PWM brightness, per-digit blink, per-digit enable and leading-zero blanking. All display inputs are snapshotted once per frame so the display never tears. It sits between application logic (counters, register files) and the board's active-low segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 1..8.
- `TICK_DIV`, 1024: clk cycles per scan tick, ≥1.
- `BRIGHT_W`, 4: brightness width; one digit dwell lasts 2^BRIGHT_W ticks.
- `BLINK_SHIFT`, 5: frame-counter bit that drives blink phase.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `digits`  in  4*NUM_DIGITS  hex values; nibble i is digit i, digit 0 rightmost.
- `decimal_points`  in  NUM_DIGITS  1 = dp lit on digit i.
- `digit_enable`  in  NUM_DIGITS  0 = digit i always dark.
- `blink`  in  NUM_DIGITS  1 = digit i blinks.
- `brightness`  in  BRIGHT_W  0 = off; 2^BRIGHT_W−1 = maximum.
- `blank_leading_zeros`  in  1  enables leading-zero suppression.
- `segments`  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- `anodes`  out  NUM_DIGITS  active-low; bit i selects digit i.
- `frame_start`  out  1  one-clk pulse when a new frame snapshot is taken.

## Operation
- Prescaler counts 0..TICK_DIV−1; `tick` is asserted on terminal count.
- Scan state: `digit_idx` (0..NUM_DIGITS−1) and `phase` (BRIGHT_W bits).
  - On each tick, `phase` increments.
  - When `phase` wraps, `digit_idx` advances 0→1→…→N−1→0.
- Frame boundary is `digit_idx` = 0, `phase` = 0. At that point:
  - all inputs are latched into snapshot registers;
  - the frame counter (BLINK_SHIFT+1 bits, wrapping) increments;
  - `frame_start` pulses.
- Digit i is lit iff all of the following hold; otherwise `anodes` = all ones and `segments` = 8'hFF:
  - `phase` ≥ 1 and `phase` ≤ snapshot brightness (phase 0 is the anti-ghosting gap);
  - snapshot enable[i] = 1;
  - not (blink[i] and frame_counter[BLINK_SHIFT] = 1);
  - not leading-zero blanked.
- Leading-zero blanking, when enabled: scan from digit N−1 downward. A digit is blanked while its value = 0 and its dp = 0. Blanking stops at the first nonzero digit or the first set dp. Digit 0 is never blanked.
- Segment decode, active-low: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110. dp bit = ~decimal_points[i].

## Timing
- Reset values:
  - `segments` = 8'hFF, `anodes` = all ones, `frame_start` = 0;
  - prescaler, `phase`, `digit_idx` and frame counter = 0;
  - snapshots = 0.
- First clock after `reset` deasserts: snapshot taken and `frame_start` = 1. The first tick follows TICK_DIV clks later.
- `segments`/`anodes` are registered. They reflect the new scan state one clk after the tick that changed it.
- Dwell per digit = 2^BRIGHT_W·TICK_DIV clks. Frame = NUM_DIGITS·dwell.
- Input changes mid-frame are invisible until the next frame boundary.
- Brightness duty = brightness/2^BRIGHT_W.
- Reset asserted mid-frame: outputs go blank on the next edge; the scan restarts from digit 0.
- NUM_DIGITS = 1: `digit_idx` constant 0; every phase wrap is a frame boundary.

## Structure
- Package `seven_seg_pkg`:
  - `SEG_BLANK` = 8'hFF;
  - hex-to-segment constant table;
  - `clog2` helper for the `digit_idx` width.
- Sub-module `hex_to_seven_seg`: combinational 4→7 active-low decoder, reused by other displays.
- Everything else (prescaler, scan counters, snapshot, blank logic, output registers) stays in one module.

## Test plan
Bench configuration for all scenarios: NUM_DIGITS=4, TICK_DIV=4, BRIGHT_W=2, BLINK_SHIFT=1; frame = 64 clk.

- Reset/basic scan: digits=16'h1234, all enables set, brightness=3. Required: anodes cycle 1110→1101→1011→0111, each low for 12 of every 16 clks, dark for the 4 phase-0 clks. Segments = decode(4,3,2,1) respectively. Blank during reset.
- Brightness: brightness=1 → each anode low 4 of 16 clks. brightness=0 → anodes stay 4'b1111 for a full frame.
- Leading zeros: digits=16'h0050, blank_leading_zeros=1 → digits 3 and 2 dark, digits 1 and 0 show 5 and 0. With decimal_points=4'b0100 → digit 2 shows "0." and digit 3 stays dark.
- Blink: blink=4'b0001 → digit 0 lit in frames where frame_counter[1]=0, dark when it is 1 (alternates every 2 frames). Other digits unaffected.
- Snapshot: change digits from 16'h1234 to 16'hABCD mid-frame → the current frame still shows 1234. ABCD appears starting on the clk after the next `frame_start`.
- Reset mid-frame during digit 2 → next edge outputs blank. After release: `frame_start` pulse, scan restarts at digit 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display family: blank pattern,
// active-low hex decode table and a width helper.
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex values 0..F.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder, shared by
// every display driver in the family.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 1..8 digit seven-segment driver with internal prescaler, PWM
// brightness, per-digit blink/enable, leading-zero blanking and frame snapshots.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1024,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_SHIFT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   decimal_points,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    blank_leading_zeros,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_start
);

  localparam int PRE_W = clog2(TICK_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PHASE_LAST = '1;

  logic [PRE_W-1:0]        prescale_reg;
  logic [BRIGHT_W-1:0]     phase_reg;
  logic [IDX_W-1:0]        digit_idx_reg;
  logic [BLINK_SHIFT:0]    frame_count_reg;
  logic [4*NUM_DIGITS-1:0] digits_snap_reg;
  logic [NUM_DIGITS-1:0]   dp_snap_reg;
  logic [NUM_DIGITS-1:0]   enable_snap_reg;
  logic [NUM_DIGITS-1:0]   blink_snap_reg;
  logic [BRIGHT_W-1:0]     bright_snap_reg;
  logic                    blz_snap_reg;
  logic [7:0]              segments_reg;
  logic [NUM_DIGITS-1:0]   anodes_reg;
  logic                    frame_start_reg;

  logic                    tick;
  logic                    frame_event;
  logic                    lit;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;
  logic [7:0]              segments_next;
  logic [NUM_DIGITS-1:0]   anodes_next;
  logic [3:0]              nibble [NUM_DIGITS];
  logic [NUM_DIGITS:0]     lz_run;

  assign tick = (prescale_reg == PRE_LAST);

  // First clk spent at digit 0 / phase 0: true right after reset and right
  // after the tick that wraps the scan, so each frame snapshots exactly once.
  assign frame_event = (digit_idx_reg == '0) && (phase_reg == '0) && (prescale_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
      assign nibble[gi] = digits_snap_reg[4*gi +: 4];
    end
  endgenerate

  // lz_run[i] stays high while every digit from the top down to i is a bare
  // zero; digit 0 is tied off so it is never suppressed.
  assign lz_run[NUM_DIGITS] = blz_snap_reg;
  assign lz_run[0]          = 1'b0;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign lz_run[gi] = lz_run[gi+1] && (nibble[gi] == 4'h0) && !dp_snap_reg[gi];
    end
  endgenerate

  assign cur_hex = nibble[digit_idx_reg];

  hex_to_seven_seg u_decoder (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Phase 0 is always dark to hide ghosting while anodes switch.
  assign lit = (phase_reg != '0)
            && (phase_reg <= bright_snap_reg)
            && enable_snap_reg[digit_idx_reg]
            && !(blink_snap_reg[digit_idx_reg] && frame_count_reg[BLINK_SHIFT])
            && !lz_run[digit_idx_reg];

  always_comb begin
    segments_next = SEG_BLANK;
    anodes_next   = '1;
    if (lit) begin
      segments_next                = {~dp_snap_reg[digit_idx_reg], cur_seg};
      anodes_next[digit_idx_reg]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_reg    <= '0;
      phase_reg       <= '0;
      digit_idx_reg   <= '0;
      frame_count_reg <= '0;
      digits_snap_reg <= '0;
      dp_snap_reg     <= '0;
      enable_snap_reg <= '0;
      blink_snap_reg  <= '0;
      bright_snap_reg <= '0;
      blz_snap_reg    <= 1'b0;
      segments_reg    <= SEG_BLANK;
      anodes_reg      <= '1;
      frame_start_reg <= 1'b0;
    end else begin
      prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
      if (tick) begin
        phase_reg <= phase_reg + 1'b1;
        if (phase_reg == PHASE_LAST) begin
          digit_idx_reg <= (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
        end
      end
      if (frame_event) begin
        digits_snap_reg <= digits;
        dp_snap_reg     <= decimal_points;
        enable_snap_reg <= digit_enable;
        blink_snap_reg  <= blink;
        bright_snap_reg <= brightness;
        blz_snap_reg    <= blank_leading_zeros;
        frame_count_reg <= frame_count_reg + 1'b1;
      end
      frame_start_reg <= frame_event;
      segments_reg    <= segments_next;
      anodes_reg      <= anodes_next;
    end
  end

  assign segments    = segments_reg;
  assign anodes      = anodes_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle model pushes expected
// outputs per clk, compared one edge later; per-frame anode duty is also checked.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int BW    = 2;
  localparam int BS    = 1;
  localparam int FRAME = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*N-1:0]  digits;
  logic [N-1:0]    decimal_points;
  logic [N-1:0]    digit_enable;
  logic [N-1:0]    blink;
  logic [BW-1:0]   brightness;
  logic            blank_leading_zeros;
  logic [7:0]      segments;
  logic [N-1:0]    anodes;
  logic            frame_start;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (N),
    .TICK_DIV    (TD),
    .BRIGHT_W    (BW),
    .BLINK_SHIFT (BS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .digits              (digits),
    .decimal_points      (decimal_points),
    .digit_enable        (digit_enable),
    .blink               (blink),
    .brightness          (brightness),
    .blank_leading_zeros (blank_leading_zeros),
    .segments            (segments),
    .anodes              (anodes),
    .frame_start         (frame_start)
  );

  typedef struct {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic         fs;
  } exp_t;

  exp_t         exp_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           t            = 0;
  int           low_cnt [N];
  logic [6:0]   hex_ref [16];
  logic [4*N-1:0] snap_digits;
  logic [N-1:0] snap_dp, snap_en, snap_blink;
  logic [BW-1:0] snap_bright;
  logic         snap_blz;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, actual, expected);
    end
  endtask

  // Model: output after edge t shows scan state after edge t-1.
  task automatic push_expected();
    exp_t       e;
    int         m, ticks, phase, idx, fc;
    logic [N-1:0] lzb;
    logic [3:0] nib;
    logic       lit;
    e.seg = 8'hFF;
    e.an  = '1;
    e.fs  = 1'b0;
    if (reset) begin
      t = 0;
    end else begin
      t++;
      if (t % FRAME == 1) begin
        snap_digits = digits;
        snap_dp     = decimal_points;
        snap_en     = digit_enable;
        snap_blink  = blink;
        snap_bright = brightness;
        snap_blz    = blank_leading_zeros;
      end
      m     = t - 1;
      ticks = m / TD;
      phase = ticks % (1 << BW);
      idx   = (ticks / (1 << BW)) % N;
      fc    = (m / FRAME + 1) % 4;
      lzb   = '0;
      if (snap_blz) begin
        for (int i = N - 1; i >= 1; i--) begin
          if (snap_digits[4*i +: 4] == 4'h0 && !snap_dp[i]) lzb[i] = 1'b1;
          else break;
        end
      end
      nib = snap_digits[4*idx +: 4];
      lit = (phase >= 1) && (phase <= int'(snap_bright)) && snap_en[idx]
         && !(snap_blink[idx] && fc[BS]) && !lzb[idx];
      if (lit) begin
        e.seg     = {~snap_dp[idx], hex_ref[nib]};
        e.an[idx] = 1'b0;
      end
      e.fs = (t % FRAME == 1);
    end
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      push_expected();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_value("segments", 32'(segments), 32'(e.seg));
      check_value("anodes", 32'(anodes), 32'(e.an));
      check_value("frame_start", 32'(frame_start), 32'(e.fs));
      for (int i = 0; i < N; i++) if (!anodes[i]) low_cnt[i]++;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) low_cnt[i] = 0;
  endtask

  task automatic check_low_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
    int req [N];
    req = '{e0, e1, e2, e3};
    $display("[TB] %s: anode low clks d0=%0d d1=%0d d2=%0d d3=%0d", tag,
             low_cnt[0], low_cnt[1], low_cnt[2], low_cnt[3]);
    for (int i = 0; i < N; i++) check_value(tag, 32'(low_cnt[i]), 32'(req[i]));
    clear_counts();
  endtask

  initial begin
    hex_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset               = 1'b1;
    digits              = 16'h1234;
    decimal_points      = 4'b0000;
    digit_enable        = 4'b1111;
    blink               = 4'b0000;
    brightness          = 2'd3;
    blank_leading_zeros = 1'b0;
    clear_counts();

    run_cycles(3);
    reset = 1'b0;
    clear_counts();
    run_cycles(FRAME);
    check_low_counts("duty_bright3", 12, 12, 12, 12);

    brightness = 2'd1;
    run_cycles(FRAME);
    check_low_counts("duty_bright1", 4, 4, 4, 4);

    brightness = 2'd0;
    run_cycles(FRAME);
    check_low_counts("duty_bright0", 0, 0, 0, 0);

    brightness          = 2'd3;
    digits              = 16'h0050;
    blank_leading_zeros = 1'b1;
    run_cycles(FRAME);
    check_low_counts("lead_zero", 12, 12, 0, 0);

    decimal_points = 4'b0100;
    run_cycles(FRAME);
    check_low_counts("lead_zero_dp", 12, 12, 12, 0);

    decimal_points      = 4'b0000;
    blank_leading_zeros = 1'b0;
    digits              = 16'h1234;
    blink               = 4'b0001;
    run_cycles(4 * FRAME);
    check_low_counts("blink_4frames", 24, 48, 48, 48);

    blink = 4'b0000;
    run_cycles(FRAME);
    run_cycles(20);
    digits = 16'hABCD;
    run_cycles(FRAME - 20);
    run_cycles(FRAME);
    check_low_counts("snapshot_3frames", 36, 36, 36, 36);

    run_cycles(36);
    reset = 1'b1;
    run_cycles(2);
    reset = 1'b0;
    clear_counts();
    run_cycles(FRAME);
    check_low_counts("after_mid_reset", 12, 12, 12, 12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
